// File: rtl/freq.sv
// freq: internal tone generator and gated frequency meter driving four 7-segment digits
module freq #(
  parameter int CLK_HZ = 50_000_000,
  parameter int HALF0  = 25_000,
  parameter int HALF1  = 5_000,
  parameter int HALF2  = 25,
  parameter int HALF3  = 250_000
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic [1:0] select,
  input  logic       modein,
  output logic       modeout,
  output logic [6:0] freqout3,
  output logic [6:0] freqout2,
  output logic [6:0] freqout1,
  output logic [6:0] freqout0
);
  localparam int GW   = $clog2(CLK_HZ + 1);
  localparam int HM01 = HALF0 > HALF1 ? HALF0 : HALF1;
  localparam int HM23 = HALF2 > HALF3 ? HALF2 : HALF3;
  localparam int HMAX = HM01 > HM23 ? HM01 : HM23;
  localparam int DW   = $clog2(HMAX + 1);
  localparam logic [GW-1:0] LEN_S  = GW'(CLK_HZ - 1);
  localparam logic [GW-1:0] LEN_MS = GW'(CLK_HZ / 1000 - 1);
  localparam logic [6:0] DASH = 7'h40;
  localparam logic [6:0] ZERO = 7'h3F;

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return DASH;
    endcase
  endfunction

  logic [GW-1:0]    gate_q, gate_d, len_m1;
  logic [1:0]       sel_q, sel_d, sel_w;
  logic             mode_q, mode_d, mode_w;
  logic [DW-1:0]    div_q, div_d, half_m1;
  logic             tone_q, tone_d, told_q, told_d;
  logic [3:0][3:0]  bcd_q, bcd_d, inc;
  logic             ovf_q, ovf_d, cout, c;
  logic [3:0][6:0]  disp_q, disp_d, segs;
  logic             modeout_q, modeout_d;
  logic             start, abort, last, clear, rise, wrap;

  // window control: inputs pass straight through on the start cycle, any later change aborts
  always_comb begin
    start  = gate_q == '0;
    sel_w  = start ? select : sel_q;
    mode_w = start ? modein : mode_q;
    len_m1 = mode_w ? LEN_MS : LEN_S;
    abort  = !start && (select != sel_q || modein != mode_q);
    last   = !abort && gate_q == len_m1;
    clear  = abort || last;
    sel_d  = sel_w;
    mode_d = mode_w;
    gate_d = clear ? '0 : gate_q + GW'(1);
  end

  // tone divider, phase-reset at every window boundary so each window counts deterministically
  always_comb begin
    half_m1 = sel_w[1] ? (sel_w[0] ? DW'(HALF3 - 1) : DW'(HALF2 - 1))
                       : (sel_w[0] ? DW'(HALF1 - 1) : DW'(HALF0 - 1));
    wrap    = div_q == half_m1;
    div_d   = clear || wrap ? '0 : div_q + DW'(1);
    tone_d  = !clear && (tone_q ^ wrap);
    told_d  = !clear && tone_q;
    rise    = tone_q && !told_q;
  end

  // BCD ripple increment on each tone rising edge; carry out of the top digit is overflow
  always_comb begin
    c   = rise;
    inc = bcd_q;
    for (int i = 0; i < 4; i++) begin
      inc[i] = c ? (bcd_q[i] == 4'd9 ? 4'd0 : bcd_q[i] + 4'd1) : bcd_q[i];
      c      = c && bcd_q[i] == 4'd9;
    end
    cout  = c;
    bcd_d = clear ? '0 : inc;
    ovf_d = !clear && (ovf_q || cout);
  end

  // display capture on the last gate cycle, including an edge landing on that cycle
  always_comb begin
    segs      = ovf_q || cout ? {4{DASH}} : {seg(inc[3]), seg(inc[2]), seg(inc[1]), seg(inc[0])};
    disp_d    = last ? segs : disp_q;
    modeout_d = last ? mode_w : modeout_q;
  end

  // state register
  always_ff @(posedge sysclk) begin
    if (rst) begin
      gate_q    <= '0;
      sel_q     <= '0;
      mode_q    <= 1'b0;
      div_q     <= '0;
      tone_q    <= 1'b0;
      told_q    <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      disp_q    <= {4{ZERO}};
      modeout_q <= 1'b0;
    end else begin
      gate_q    <= gate_d;
      sel_q     <= sel_d;
      mode_q    <= mode_d;
      div_q     <= div_d;
      tone_q    <= tone_d;
      told_q    <= told_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      disp_q    <= disp_d;
      modeout_q <= modeout_d;
    end
  end

  assign modeout  = modeout_q;
  assign freqout3 = disp_q[3];
  assign freqout2 = disp_q[2];
  assign freqout1 = disp_q[1];
  assign freqout0 = disp_q[0];
endmodule

// File: tb/tb_freq.sv
// tb_freq: scoreboard bench for freq with scaled clock and arithmetic edge-count model
module tb_freq;
  localparam int CLK = 20000;
  localparam int NMS = CLK / 1000;
  localparam int H0 = 10, H1 = 2, H2 = 1, H3 = 100;

  logic sysclk = 0, rst = 1, modein = 0, modeout;
  logic [1:0] select = 0;
  logic [6:0] freqout3, freqout2, freqout1, freqout0;

  freq #(.CLK_HZ(CLK), .HALF0(H0), .HALF1(H1), .HALF2(H2), .HALF3(H3)) dut (
    .sysclk(sysclk), .rst(rst), .select(select), .modein(modein), .modeout(modeout),
    .freqout3(freqout3), .freqout2(freqout2), .freqout1(freqout1), .freqout0(freqout0));

  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  typedef struct { int when; logic [27:0] segs; logic mode; } exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  int hv[4] = '{H0, H1, H2, H3};
  logic [27:0] rst_segs = {4{7'h3F}};

  function automatic logic [6:0] seg7(int d);
    logic [6:0] t [10];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return t[d];
  endfunction

  // rising edges fall at odd multiples of the half period within gate cycles 0..n-1
  function automatic logic [27:0] model(int s, int m);
    int n, cnt;
    n = m ? NMS : CLK;
    cnt = ((n - 1) / hv[s] + 1) / 2;
    if (cnt > 9999) return {4{7'h40}};
    return {seg7(cnt / 1000), seg7(cnt / 100 % 10), seg7(cnt / 10 % 10), seg7(cnt % 10)};
  endfunction

  task automatic chk(string name, exp_t e);
    total++;
    if ({freqout3, freqout2, freqout1, freqout0} !== e.segs || modeout !== e.mode) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h/%b exp=%h/%b", name, cyc,
               {freqout3, freqout2, freqout1, freqout0}, modeout, e.segs, e.mode);
    end
  endtask

  initial begin
    exp_t cur;
    cur = '{0, rst_segs, 1'b0};
    forever begin
      @(negedge sysclk);
      if (q.size() > 0 && cyc > q[0].when) begin
        total++;
        bad++;
        $display("FAIL missed cyc=%0d got=- exp=update at %0d", cyc, q[0].when);
        cur = q.pop_front();
      end
      if (q.size() > 0 && cyc == q[0].when) begin
        cur = q.pop_front();
        chk("update", cur);
      end else if (q.size() > 0 && cyc == q[0].when - 1) chk("hold", cur);
      if (rst) chk("reset", cur);
    end
  end

  task automatic win(int s, int m);
    int n;
    n = m ? NMS : CLK;
    select = 2'(s);
    modein = 1'(m);
    q.push_back('{cyc + n, model(s, m), 1'(m)});
    repeat (n) @(negedge sysclk);
  endtask

  task automatic abt(int s, int m, int j, int s2, int m2);
    select = 2'(s);
    modein = 1'(m);
    repeat (j) @(negedge sysclk);
    select = 2'(s2);
    modein = 1'(m2);
    @(negedge sysclk);
  endtask

  task automatic rst_mid(int s, int m, int j);
    select = 2'(s);
    modein = 1'(m);
    repeat (j) @(negedge sysclk);
    rst = 1;
    q.push_back('{cyc + 1, rst_segs, 1'b0});
    repeat (2) @(negedge sysclk);
    rst = 0;
  endtask

  initial begin
    int s, s2, r, j;
    repeat (2) @(negedge sysclk);
    rst = 0;
    win(0, 0);
    win(2, 1);
    win(2, 0);
    win(3, 0);
    abt(3, 0, 1 + $urandom % 100, 3, 1);
    win(3, 1);
    abt(1, 1, NMS / 2, 0, 1);
    win(0, 1);
    for (int k = 0; k < 30; k++) begin
      s = $urandom % 4;
      r = $urandom % 4;
      j = 1 + $urandom % (NMS - 2);
      s2 = (s + 1 + $urandom % 3) % 4;
      if (r == 0) win(s, 1);
      else if (r == 1) begin
        abt(s, 1, j, s2, 1);
        win(s2, 1);
      end else if (r == 2) begin
        rst_mid(s, 1, j);
        win(s, 1);
      end else begin
        abt(s, 0, j, s, 1);
        win(s, 1);
      end
    end
    repeat (3) @(negedge sysclk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL pending got=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
